// File: rtl/img_edge_pipeline.sv
// Framed RGB pixel stream -> gray -> 3x3 Sobel magnitude, output mode selected per frame.
// Optional IMG_EDGE_COUNT_EN adds edge_count / edge_count_valid (per-frame edge total).
module img_edge_pipeline #(
   parameter int IMG_WIDTH         = 640,
   parameter int IMG_HEIGHT        = 480,
   parameter int DATA_W            = 8,
   parameter int DEFAULT_THRESHOLD = 150
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din_valid,
   input  logic              din_sof,
   input  logic [DATA_W-1:0] r_data,
   input  logic [DATA_W-1:0] g_data,
   input  logic [DATA_W-1:0] b_data,
   input  logic [1:0]        cfg_mode,
   input  logic [DATA_W-1:0] cfg_threshold,
   input  logic              err_clr,
   output logic              dout_valid,
   output logic              dout_sof,
   output logic              dout_eol,
   output logic [DATA_W-1:0] dout_data,
   output logic              busy,
   output logic              frame_err
`ifdef IMG_EDGE_COUNT_EN
   ,
   output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] edge_count,
   output logic              edge_count_valid
`endif
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT + 2);
   localparam int GW = DATA_W + 3;
   localparam int PW = DATA_W + 8;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     col_reg;
   logic [RW-1:0]     row_reg;
   logic [1:0]        shadow_mode_reg;
   logic [DATA_W-1:0] shadow_thr_reg;

   logic              start, accept, adv, last_in, emit, err_set;
   logic [CW-1:0]     adv_col, cen_col;
   logic [RW-1:0]     adv_row, cen_row;
   logic [DATA_W-1:0] gray_in, adv_pix;

   // Line buffers: lb0 holds the previous row, lb1 the one before it
   logic [DATA_W-1:0] lb0 [IMG_WIDTH];
   logic [DATA_W-1:0] lb1 [IMG_WIDTH];
   logic [DATA_W-1:0] rd_top, rd_mid, rd_bot;
   logic [CW-1:0]     wr1_col;

   logic [DATA_W-1:0] c0_t, c0_m, c0_b, c1_t, c1_m, c1_b;

   logic              s1_valid, s1_sof, s1_eol, s1_border;
   logic [1:0]        s1_mode;
   logic [DATA_W-1:0] s1_thr;
   logic signed [GW-1:0] gx, gy;

   logic              s2_valid, s2_sof, s2_eol, s2_border;
   logic [1:0]        s2_mode;
   logic [DATA_W-1:0] s2_thr, s2_gray;
   logic signed [GW-1:0] s2_gx, s2_gy;

   logic [GW-1:0]     ax, ay;
   logic [GW:0]       mag_sum;
   logic [DATA_W-1:0] mag, out_pix;
   logic              edge_hit;

   assign gray_in = DATA_W'((PW'(r_data) * PW'(77) + PW'(g_data) * PW'(150)
                             + PW'(b_data) * PW'(29)) >> 8);

   assign start   = din_valid & din_sof & (state_reg != FLUSH);
   assign accept  = start | ((state_reg == RUN) & din_valid);
   assign adv     = accept | (state_reg == FLUSH);
   assign adv_col = start ? '0 : col_reg;
   assign adv_row = start ? '0 : row_reg;
   assign adv_pix = accept ? gray_in : '0;
   assign last_in = (adv_row == RW'(IMG_HEIGHT - 1)) && (adv_col == CW'(IMG_WIDTH - 1));
   assign err_set = din_valid & (((state_reg == RUN) & din_sof) | (state_reg == FLUSH));
   assign busy    = (state_reg != IDLE);

   // Advance n supplies linear pixel n and completes centre n-(IMG_WIDTH+1)
   assign emit    = adv && ((adv_row >= RW'(2)) || ((adv_row == RW'(1)) && (adv_col != '0)));
   assign cen_col = (adv_col == '0) ? CW'(IMG_WIDTH - 1) : adv_col - CW'(1);
   assign cen_row = (adv_col == '0) ? adv_row - RW'(2) : adv_row - RW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (accept && last_in) state_next = FLUSH;
         FLUSH:   if (adv_row == RW'(IMG_HEIGHT + 1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_reg         <= '0;
         row_reg         <= '0;
         shadow_mode_reg <= 2'd1;
         shadow_thr_reg  <= DATA_W'(DEFAULT_THRESHOLD);
         frame_err       <= 1'b0;
      end else begin
         if (adv) begin
            if (adv_col == CW'(IMG_WIDTH - 1)) begin
               col_reg <= '0;
               row_reg <= adv_row + RW'(1);
            end else begin
               col_reg <= adv_col + CW'(1);
               row_reg <= adv_row;
            end
         end
         if (start) begin
            shadow_mode_reg <= cfg_mode;
            shadow_thr_reg  <= cfg_threshold;
         end
         if (err_set)      frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
      end
   end

   // lb1 is fed from lb0's registered read one advance late, so both stay single-port
   always_ff @(posedge clk) begin
      if (adv) begin
         rd_top       <= lb1[adv_col];
         rd_mid       <= lb0[adv_col];
         rd_bot       <= adv_pix;
         lb0[adv_col] <= adv_pix;
         lb1[wr1_col] <= rd_mid;
         wr1_col      <= adv_col;
      end
   end

   function automatic logic signed [GW-1:0] sx(input logic [DATA_W-1:0] v);
      return $signed({3'b000, v});
   endfunction

   assign gx = (sx(rd_top) + (sx(rd_mid) <<< 1) + sx(rd_bot))
             - (sx(c0_t) + (sx(c0_m) <<< 1) + sx(c0_b));
   assign gy = (sx(c0_b) + (sx(c1_b) <<< 1) + sx(rd_bot))
             - (sx(c0_t) + (sx(c1_t) <<< 1) + sx(rd_top));

   assign ax       = s2_gx[GW-1] ? $unsigned(-s2_gx) : $unsigned(s2_gx);
   assign ay       = s2_gy[GW-1] ? $unsigned(-s2_gy) : $unsigned(s2_gy);
   assign mag_sum  = {1'b0, ax} + {1'b0, ay};
   assign mag      = (|mag_sum[GW:DATA_W]) ? '1 : mag_sum[DATA_W-1:0];
   assign edge_hit = !s2_border && (mag >= s2_thr);

   always_comb begin
      out_pix = '0;
      case (s2_mode)
         2'd0: out_pix = s2_gray;
         2'd1: out_pix = s2_border ? '0 : mag;
         2'd2: out_pix = edge_hit ? '1 : '0;
         2'd3: out_pix = (s2_border || edge_hit) ? '0 : '1;
         default: out_pix = '0;
      endcase
   end

   // Window columns c0, c1 plus the read registers as the newest column
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c0_t <= '0; c0_m <= '0; c0_b <= '0;
         c1_t <= '0; c1_m <= '0; c1_b <= '0;
         s1_valid <= 1'b0; s1_sof <= 1'b0; s1_eol <= 1'b0; s1_border <= 1'b0;
         s1_mode  <= '0;   s1_thr <= '0;
         s2_valid <= 1'b0; s2_sof <= 1'b0; s2_eol <= 1'b0; s2_border <= 1'b0;
         s2_mode  <= '0;   s2_thr <= '0;   s2_gray <= '0;
         s2_gx    <= '0;   s2_gy  <= '0;
         dout_valid <= 1'b0; dout_sof <= 1'b0; dout_eol <= 1'b0; dout_data <= '0;
      end else begin
         if (adv) begin
            c0_t <= c1_t;   c0_m <= c1_m;   c0_b <= c1_b;
            c1_t <= rd_top; c1_m <= rd_mid; c1_b <= rd_bot;
         end
         s1_valid  <= emit;
         s1_sof    <= emit && (cen_row == '0) && (cen_col == '0);
         s1_eol    <= emit && (cen_col == CW'(IMG_WIDTH - 1));
         s1_border <= (cen_row == '0) || (cen_row == RW'(IMG_HEIGHT - 1))
                   || (cen_col == '0) || (cen_col == CW'(IMG_WIDTH - 1));
         s1_mode   <= shadow_mode_reg;
         s1_thr    <= shadow_thr_reg;

         s2_valid  <= s1_valid;
         s2_sof    <= s1_sof;
         s2_eol    <= s1_eol;
         s2_border <= s1_border;
         s2_mode   <= s1_mode;
         s2_thr    <= s1_thr;
         s2_gray   <= c1_m;
         s2_gx     <= gx;
         s2_gy     <= gy;

         dout_valid <= s2_valid;
         dout_sof   <= s2_valid & s2_sof;
         dout_eol   <= s2_valid & s2_eol;
         dout_data  <= s2_valid ? out_pix : '0;
      end
   end

`ifdef IMG_EDGE_COUNT_EN
   localparam int EW = $clog2(IMG_WIDTH*IMG_HEIGHT+1);
   logic          s1_last, s2_last, out_last_reg;
   logic [EW-1:0] acc_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_last <= 1'b0; s2_last <= 1'b0; out_last_reg <= 1'b0;
         acc_reg <= '0; edge_count <= '0; edge_count_valid <= 1'b0;
      end else begin
         s1_last      <= emit && (cen_row == RW'(IMG_HEIGHT - 1)) && (cen_col == CW'(IMG_WIDTH - 1));
         s2_last      <= s1_last;
         out_last_reg <= s2_valid & s2_last;
         if (s2_valid) acc_reg <= (s2_sof ? '0 : acc_reg) + EW'(edge_hit);
         edge_count_valid <= out_last_reg;
         if (out_last_reg) edge_count <= acc_reg;
      end
   end
`endif

endmodule
